// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: packer FSM states and IEEE-754 single-precision field sizes.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } packer_state_t;

    localparam int FP_EXP_BIAS  = 127;
    localparam int FP_MANT_BITS = 23;
    localparam int FP_EXP_BITS  = 8;

endpackage

// File: rtl/packer_round.sv
// Builds the packed float from a normalised magnitude: RNE rounding, mantissa carry,
// exponent, flush-to-zero and saturate-to-infinity.
module packer_round
    import cordic_pkg::*;
#(
    parameter int FRACTIONAL_BITS = 30
) (
    input  logic [31:0] mag,
    input  logic [4:0]  s,
    input  logic        sign,
    output logic [31:0] fp
);

    localparam logic signed [9:0] E0 = 10'(FP_EXP_BIAS + 31 - FRACTIONAL_BITS);

    logic signed [9:0]         e;
    logic [FP_MANT_BITS:0]     mant_r;
    logic                      guard, sticky, rnd;

    always_comb begin
        guard  = mag[7];
        sticky = |mag[6:0];
        rnd    = guard && (sticky || mag[8]);
        mant_r = {1'b0, mag[30:8]} + {{FP_MANT_BITS{1'b0}}, rnd};
        e      = E0 - $signed({5'b0, s});
        // Rounding overflowed the mantissa: it becomes 1.0 of the next binade.
        if (mant_r[FP_MANT_BITS]) begin
            e = e + 10'sd1;
        end

        if (mag == 32'h0) begin
            fp = 32'h0;
        end else if (e <= 10'sd0) begin
            fp = {sign, 31'h0};
        end else if (e >= 10'sd255) begin
            fp = {sign, 8'hFF, 23'h0};
        end else begin
            fp = {sign, e[7:0], mant_r[FP_MANT_BITS-1:0]};
        end
    end

endmodule

// File: rtl/packer.sv
// Fixed-point to IEEE-754 single converter: bit-serial normalisation, one rounding
// cycle, then holds the result until the consumer takes it.
module packer
    import cordic_pkg::*;
#(
    parameter int FRACTIONAL_BITS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    packer_state_t state_q, state_d;
    logic [31:0]   mag_q, mag_d;
    logic [4:0]    s_q, s_d;
    logic          sign_q, sign_d;
    logic [31:0]   out_q, out_d;
    logic          ovld_q, ovld_d;
    logic [31:0]   fp;

    packer_round #(.FRACTIONAL_BITS(FRACTIONAL_BITS)) u_round (
        .mag  (mag_q),
        .s    (s_q),
        .sign (sign_q),
        .fp   (fp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mag_q   <= 32'h0;
            s_q     <= 5'd0;
            sign_q  <= 1'b0;
            out_q   <= 32'h0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            s_q     <= s_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
            ovld_q  <= ovld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        s_d     = s_q;
        sign_d  = sign_q;
        out_d   = out_q;
        ovld_d  = ovld_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[31];
                    // Two's-complement negate; 0x80000000 maps onto itself as unsigned.
                    mag_d   = in_data[31] ? (~in_data + 32'd1) : in_data;
                    s_d     = 5'd0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q[31] || mag_q == 32'h0) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    s_d   = s_q + 5'd1;
                end
            end
            ROUND: begin
                out_d   = fp;
                ovld_d  = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ovld_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_packer.sv
// Directed and random checks of the fixed-point to float packer (Q1.30 input).
module tb_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    packer #(.FRACTIONAL_BITS(30)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued conversion to single with round-to-nearest-even.
    function automatic logic [31:0] ref_fp(input logic [31:0] d);
        real    r, m, f;
        int     e;
        longint mi;
        logic   sg;
        sg = d[31];
        r  = $itor($signed(d)) / 1073741824.0;
        if (sg) r = -r;
        if (r == 0.0) return 32'h0;
        e = 0;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        m  = r * 8388608.0;
        mi = longint'($floor(m));
        f  = m - $itor(mi);
        if (f > 0.5 || (f == 0.5 && mi[0])) mi++;
        if (mi >= 64'd16777216) begin mi = mi / 2; e++; end
        return {sg, 8'(e + 127), mi[22:0]};
    endfunction

    // Send one word, wait for the result, check data and latency, then handshake.
    task automatic xfer(input logic [31:0] d, input logic [31:0] exp, input int lat, input string tag);
        int n;
        @(negedge clk);
        chk({31'h0, in_ready}, 32'h1, {tag, "_in_ready"});
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({31'h0, out_valid}, 32'h1, {tag, "_valid"});
        chk(out_data, exp, {tag, "_data"});
        if (lat >= 0) chk(32'(n), 32'(lat), {tag, "_latency"});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({31'h0, out_valid}, 32'h0, {tag, "_drop"});
    endtask

    initial begin
        logic [31:0] held, w;
        int          seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({31'h0, in_ready},  32'h1, "rst_in_ready");
        chk({31'h0, out_valid}, 32'h0, "rst_out_valid");
        chk(out_data,           32'h0, "rst_out_data");
        reset = 1'b0;

        xfer(32'h40000000, 32'h3F800000, 3,  "pos_one");
        xfer(32'hC0000000, 32'hBF800000, 3,  "neg_one");
        xfer(32'h80000000, 32'hC0000000, 2,  "neg_two");
        xfer(32'h00000000, 32'h00000000, 2,  "zero");
        xfer(32'h00000001, 32'h30800000, 33, "lsb");
        xfer(32'h40000040, 32'h3F800000, 3,  "rne_tie_even");
        xfer(32'h400000C0, 32'h3F800002, 3,  "rne_tie_odd");
        xfer(32'h7FFFFFFF, 32'h40000000, 3,  "rne_carry");

        // Backpressure: result held, input blocked, competing word ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h40000000;
        @(posedge clk); #1;
        in_data  = 32'h20000000;
        seen = 0;
        while (!out_valid && seen < 50) begin @(posedge clk); #1; seen++; end
        chk(out_data, 32'h3F800000, "bp_first");
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk(out_data, held, "bp_stable");
            chk({30'h0, out_valid, in_ready}, 32'h2, "bp_flags");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({30'h0, out_valid, in_ready}, 32'h1, "bp_release");
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk(32'(seen), 32'h0, "bp_ignored");

        // Reset while normalising drops the word.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h00000001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk({30'h0, out_valid, in_ready}, 32'h1, "mid_rst_flags");
        chk(out_data, 32'h0, "mid_rst_data");
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk(32'(seen), 32'h0, "mid_rst_no_out");

        // Random sweep across magnitudes and signs.
        for (int i = 0; i < 40; i++) begin
            w = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) w = ~w + 32'd1;
            xfer(w, ref_fp(w), -1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
